// File: rtl/imm_ext_pipe_if.sv
// Decode-to-execute handshake bundle for the immediate extender.
interface imm_ext_pipe_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;

  // Producer/consumer side (decode stage plus execute-stage ready).
  modport master (
    output flush, in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  // Extender side.
  modport slave (
    input  flush, in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: zero/sign/upper/branch widening into a
// registered output stage backed by a one-entry skid register.
module imm_ext_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  imm_ext_pipe_if.slave bus
);

  localparam int unsigned PAD_W  = OUT_W - IN_W;
  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ZERO  = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SIGN  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_UPPER = 2'b10;

  // State encoding is {O.valid, S.valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t             state;
  state_t             state_n;
  logic               o_valid;
  logic               s_valid;
  logic [OUT_W-1:0]   o_data;
  logic [MODE_W-1:0]  o_mode;
  logic [OUT_W-1:0]   s_data;
  logic [MODE_W-1:0]  s_mode;

  logic [OUT_W-1:0]   zext_c;
  logic [OUT_W-1:0]   sext_c;
  logic [OUT_W-1:0]   ext_c;
  logic               accept_c;
  logic               load_o_in_c;
  logic               load_o_skid_c;
  logic               load_s_c;

  assign {o_valid, s_valid} = state;

  // Extension datapath; result is only captured on acceptance.
  always_comb begin
    zext_c = {{PAD_W{1'b0}}, bus.in_imm};
    sext_c = {{PAD_W{bus.in_imm[IN_W-1]}}, bus.in_imm};
    ext_c  = zext_c;
    case (bus.in_mode)
      MODE_ZERO:  ext_c = zext_c;
      MODE_SIGN:  ext_c = sext_c;
      MODE_UPPER: ext_c = {bus.in_imm, {PAD_W{1'b0}}};
      default:    ext_c = {sext_c[OUT_W-3:0], 2'b00};
    endcase
  end

  assign accept_c = bus.in_valid && !s_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and register load selects; flush overrides everything.
  always_comb begin
    state_n       = state;
    load_o_in_c   = 1'b0;
    load_o_skid_c = 1'b0;
    load_s_c      = 1'b0;
    if (bus.flush) begin
      state_n = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept_c) begin
            load_o_in_c = 1'b1;
            state_n     = ST_HALF;
          end
        end
        ST_HALF: begin
          if (accept_c && bus.out_ready) begin
            load_o_in_c = 1'b1;
          end else if (accept_c) begin
            load_s_c = 1'b1;
            state_n  = ST_FULL;
          end else if (bus.out_ready) begin
            state_n = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            load_o_skid_c = 1'b1;
            state_n       = ST_HALF;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  // Output and skid data registers; contents are qualified by the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= '0;
      o_mode <= '0;
      s_data <= '0;
      s_mode <= '0;
    end else begin
      if (load_o_in_c) begin
        o_data <= ext_c;
        o_mode <= bus.in_mode;
      end else if (load_o_skid_c) begin
        o_data <= s_data;
        o_mode <= s_mode;
      end
      if (load_s_c) begin
        s_data <= ext_c;
        s_mode <= bus.in_mode;
      end
    end
  end

  assign bus.in_ready  = !s_valid;
  assign bus.out_valid = o_valid;
  assign bus.out_data  = o_data;
  assign bus.out_mode  = o_mode;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe with a scoreboard of expected results.
module tb_imm_ext_pipe;

  logic clk;
  logic rst_n;

  imm_ext_pipe_if #(.IN_W(16), .OUT_W(32)) bus ();
  imm_ext_pipe_if #(.IN_W(12), .OUT_W(24)) bus12 ();

  imm_ext_pipe #(.IN_W(16), .OUT_W(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  imm_ext_pipe #(.IN_W(12), .OUT_W(24)) u_dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus12.slave)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  mode;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n_out = 0;

  logic [15:0] sw_imm  [9] = '{16'h8003, 16'h7FFF, 16'h1234, 16'hFFFF, 16'h0001,
                               16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [1:0]  sw_mode [9] = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [31:0] sw_exp  [9] = '{32'hFFFF8003, 32'h00007FFF, 32'h12340000, 32'hFFFFFFFC,
                               32'h00000004, 32'h0, 32'h0, 32'h0, 32'h0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extension for IN_W=16, OUT_W=32.
  function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
    case (mode)
      2'd0:    return {16'h0000, imm};
      2'd1:    return {{16{imm[15]}}, imm};
      2'd2:    return {imm, 16'h0000};
      default: return {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode);
    bus.in_valid = v;
    bus.in_imm   = imm;
    bus.in_mode  = mode;
  endtask

  // Scoreboard: push on acceptance, pop and compare on each delivered result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_data", bus.out_data, e.data);
          chk("sb_mode", 32'(bus.out_mode), 32'(e.mode));
        end
      end
      if (bus.in_valid && bus.in_ready && !bus.flush) begin
        sb.push_back('{data: model(bus.in_imm, bus.in_mode), mode: bus.in_mode});
      end
    end
  end

  initial begin
    int base;
    // Reset with a pending input held on the bus.
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h8003, 2'd0);
    bus12.flush = 1'b0;
    bus12.out_ready = 1'b1;
    bus12.in_valid = 1'b0;
    bus12.in_imm = 12'h000;
    bus12.in_mode = 2'd0;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_mode", 32'(bus.out_mode), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 16'h0, 2'd0);
    rst_n = 1'b1;
    tick();
    drive(1'b1, 16'h8003, 2'd0);
    tick();
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_data", bus.out_data, 32'h00008003);
    drive(1'b0, 16'h0, 2'd0);
    tick();

    // Mode sweep, one per cycle.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, sw_imm[i], sw_mode[i]);
      tick();
      chk("sweep_data", bus.out_data, sw_exp[i]);
      chk("sweep_mode", 32'(bus.out_mode), 32'(sw_mode[i]));
    end
    drive(1'b0, 16'h0, 2'd0);
    tick();
    chk("sweep_drained", 32'(bus.out_valid), 32'd0);

    // Back-pressure: A, B held; C waits at the input.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hAAAA, 2'd1);
    tick();
    chk("bp_in_ready_after_a", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 16'h0BBB, 2'd2);
    tick();
    chk("bp_in_ready_after_b", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_a", bus.out_data, 32'hFFFFAAAA);
    drive(1'b1, 16'h0CCC, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_stable_a", bus.out_data, 32'hFFFFAAAA);
    end
    bus.out_ready = 1'b1;
    tick();
    chk("bp_deliver_b", bus.out_data, 32'h0BBB0000);
    chk("bp_ready_back", 32'(bus.in_ready), 32'd1);
    tick();
    chk("bp_deliver_c", bus.out_data, 32'h00000CCC);
    drive(1'b0, 16'h0, 2'd0);
    tick();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Full throughput: eight back-to-back results.
    base = n_out;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(16'h9000 + 16'(i * 16'h0123)), 2'(i));
      tick();
      chk("tp_valid", 32'(bus.out_valid), 32'd1);
      chk("tp_ready", 32'(bus.in_ready), 32'd1);
      chk("tp_data", bus.out_data, model(16'(16'h9000 + 16'(i * 16'h0123)), 2'(i)));
    end
    drive(1'b0, 16'h0, 2'd0);
    tick();
    chk("tp_count", 32'(n_out - base), 32'd8);

    // Flush while FULL with a new input offered.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h1111, 2'd0);
    tick();
    drive(1'b1, 16'h2222, 2'd0);
    tick();
    chk("fl_full", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 16'h3333, 2'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 16'h0, 2'd0);
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_in_ready", 32'(bus.in_ready), 32'd1);
    sb.delete();
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("fl_stays_empty", 32'(bus.out_valid), 32'd0);

    // Flush in HALF with a simultaneous accept: the new input is discarded.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h4444, 2'd1);
    tick();
    drive(1'b1, 16'h5555, 2'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 16'h0, 2'd0);
    chk("fl_half_valid", 32'(bus.out_valid), 32'd0);
    sb.delete();
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("fl_half_empty", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-operation clears held results without an edge.
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h6666, 2'd0);
    tick();
    drive(1'b1, 16'h7777, 2'd0);
    tick();
    drive(1'b0, 16'h0, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_data", bus.out_data, 32'h0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();

    // Narrow variant IN_W=12, OUT_W=24.
    bus12.in_valid = 1'b1;
    bus12.in_imm = 12'h800;
    bus12.in_mode = 2'd1;
    tick();
    chk("w12_sign", 32'(bus12.out_data), 32'h00FFF800);
    bus12.in_mode = 2'd2;
    tick();
    chk("w12_upper", 32'(bus12.out_data), 32'h00800000);
    bus12.in_mode = 2'd3;
    tick();
    chk("w12_branch", 32'(bus12.out_data), 32'h00FFE000);
    bus12.in_mode = 2'd0;
    tick();
    chk("w12_zero", 32'(bus12.out_data), 32'h00000800);
    bus12.in_valid = 1'b0;
    tick();
    chk("w12_drained", 32'(bus12.out_valid), 32'd0);

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
